// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: picks one of four free-running pattern generators,
// inserts a blank gap on every switch, and advances on buttons or a dwell timer.
module led_pattern_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned BLANK_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic       pause,
    input  logic       dir_sw,
    input  logic [9:0] pat0,
    input  logic [9:0] pat1,
    input  logic [9:0] pat2,
    input  logic [9:0] pat3,
    output logic [3:0] pat_en,
    output logic [3:0] pat_rst,
    output logic       pat_dir,
    output logic [9:0] led,
    output logic [1:0] sel,
    output logic       running,
    output logic       adv
);

    localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
    localparam logic [BlankW-1:0] BlankLast =
        BlankW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StSwitch, StBlank, StRun} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [BlankW-1:0] blank_q, blank_d;
    logic              btn_next_q, btn_next_d;
    logic              btn_prev_q, btn_prev_d;
    logic              pat_dir_q, pat_dir_d;
    logic              adv_q, adv_d;

    logic       next_edge;
    logic       prev_edge;
    logic       auto_step;
    logic       dwell_active;
    logic [3:0] sel_onehot;
    logic [9:0] pat_sel;

    // State and counter registers; reset lands in SWITCH so pattern 0 gets its reset pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSwitch;
            sel_q      <= 2'd0;
            dwell_q    <= '0;
            blank_q    <= '0;
            btn_next_q <= 1'b0;
            btn_prev_q <= 1'b0;
            pat_dir_q  <= 1'b0;
            adv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            dwell_q    <= dwell_d;
            blank_q    <= blank_d;
            btn_next_q <= btn_next_d;
            btn_prev_q <= btn_prev_d;
            pat_dir_q  <= pat_dir_d;
            adv_q      <= adv_d;
        end
    end

    // Next-state: advance events are only honoured in RUN; edges elsewhere are dropped.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        dwell_d    = dwell_q;
        blank_d    = blank_q;
        adv_d      = 1'b0;
        // Edge registers track the raw level every cycle, so a level held through
        // SWITCH/BLANK (or through reset) never turns into a late edge.
        btn_next_d = btn_next;
        btn_prev_d = btn_prev;
        pat_dir_d  = dir_sw;

        next_edge    = btn_next & ~btn_next_q;
        prev_edge    = btn_prev & ~btn_prev_q;
        dwell_active = auto_en & ~pause;
        auto_step    = dwell_active & (dwell_q == DwellLast);

        case (state_q)
            StSwitch: begin
                if (BLANK_CYCLES == 0) begin
                    state_d = StRun;
                    dwell_d = '0;
                end else begin
                    state_d = StBlank;
                    blank_d = '0;
                end
            end
            StBlank: begin
                if (blank_q == BlankLast) begin
                    state_d = StRun;
                    dwell_d = '0;
                end else begin
                    blank_d = blank_q + BlankW'(1);
                end
            end
            StRun: begin
                if (next_edge || (!prev_edge && auto_step)) begin
                    sel_d   = sel_q + 2'd1;
                    state_d = StSwitch;
                    adv_d   = 1'b1;
                end else if (prev_edge) begin
                    sel_d   = sel_q - 2'd1;
                    state_d = StSwitch;
                    adv_d   = 1'b1;
                end else if (dwell_active && (dwell_q != DwellLast)) begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            default: state_d = StSwitch;
        endcase
    end

    // Output decode: generator control and LED mux depend only on state, sel and pause.
    always_comb begin
        sel_onehot = 4'b0001 << sel_q;
        pat_sel    = pat0;
        case (sel_q)
            2'd0:    pat_sel = pat0;
            2'd1:    pat_sel = pat1;
            2'd2:    pat_sel = pat2;
            default: pat_sel = pat3;
        endcase

        pat_en  = 4'b0000;
        pat_rst = 4'b0000;
        led     = 10'h000;
        running = 1'b0;
        case (state_q)
            StSwitch: pat_rst = sel_onehot;
            StRun: begin
                pat_en  = pause ? 4'b0000 : sel_onehot;
                led     = pat_sel;
                running = ~pause;
            end
            default: ;
        endcase
    end

    assign pat_dir = pat_dir_q;
    assign sel     = sel_q;
    assign adv     = adv_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus a
// randomized run compared cycle-by-cycle against a timeline-based model.
module tb_led_pattern_sequencer;

    localparam int D = 8;
    localparam int B = 3;

    logic clk = 1'b0;
    logic rst, btn_next, btn_prev, auto_en, pause, dir_sw;
    logic [9:0] pats [4] = '{10'h001, 10'h002, 10'h004, 10'h008};

    logic [3:0]  pat_en, pat_rst;
    logic        pat_dir, running, adv;
    logic [9:0]  led;
    logic [1:0]  sel;
    logic [22:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the pattern timeline is tracked as the age (cycles since the
    // last step) plus the number of dwell-counted RUN cycles.
    int m_sel, m_age, m_run;
    bit m_bn, m_bp, m_dir, m_adv;

    led_pattern_sequencer #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en (auto_en),
        .pause   (pause),
        .dir_sw  (dir_sw),
        .pat0    (pats[0]),
        .pat1    (pats[1]),
        .pat2    (pats[2]),
        .pat3    (pats[3]),
        .pat_en  (pat_en),
        .pat_rst (pat_rst),
        .pat_dir (pat_dir),
        .led     (led),
        .sel     (sel),
        .running (running),
        .adv     (adv)
    );

    assign dut_vec = {pat_en, pat_rst, pat_dir, led, sel, running, adv};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_edge();
        bit ne, pe, in_run;
        int stp;
        if (rst) begin
            m_sel = 0; m_age = 0; m_run = 0;
            m_bn = 1'b0; m_bp = 1'b0; m_dir = 1'b0; m_adv = 1'b0;
            return;
        end
        ne     = btn_next && !m_bn;
        pe     = btn_prev && !m_bp;
        in_run = (m_age > B);
        stp    = 0;
        if (in_run) begin
            if (ne) stp = 1;
            else if (pe) stp = 3;
            else if (auto_en && !pause && m_run == D - 1) stp = 1;
        end
        if (stp != 0) begin
            m_sel = (m_sel + stp) % 4;
            m_age = 0;
            m_run = 0;
            m_adv = 1'b1;
        end else begin
            m_adv = 1'b0;
            if (in_run && auto_en && !pause) m_run++;
            if (m_age < 1000) m_age++;
        end
        m_bn  = btn_next;
        m_bp  = btn_prev;
        m_dir = dir_sw;
    endtask

    function automatic logic [22:0] model_out();
        logic [3:0] oh;
        logic sw, run;
        oh  = 4'b0001 << m_sel;
        sw  = (m_age == 0);
        run = (m_age > B);
        return {(run && !pause) ? oh : 4'b0000, sw ? oh : 4'b0000, m_dir,
                run ? pats[m_sel] : 10'h000, 2'(m_sel), run && !pause, m_adv};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0;
        auto_en = 1'b1; pause = 1'b0; dir_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({pat_rst, pat_en, led, sel, running, adv, pat_dir} !==
                {4'b0001, 4'b0000, 10'h000, 2'd0, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_state: got rst=%b en=%b led=%h sel=%0d run=%b adv=%b dir=%b, want 0001/0000/000/0/0/0/0",
                         pat_rst, pat_en, led, sel, running, adv, pat_dir);
            end
        end
    endtask

    task automatic test_auto_cycle();
        rst = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            tick();
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL auto_model n=%0d: got %h want %h", n, dut_vec, model_out());
            end
            n_cmp++;
            if (adv !== ((n % 12) == 0)) begin
                n_bad++;
                $display("FAIL auto_adv n=%0d: got %b want %b", n, adv, (n % 12) == 0);
            end
            if ((n % 12) == 0) begin
                n_cmp++;
                if (sel !== 2'((n / 12) % 4)) begin
                    n_bad++;
                    $display("FAIL auto_sel n=%0d: got %0d want %0d", n, sel, (n / 12) % 4);
                end
            end
            if (n <= 11) begin
                n_cmp++;
                if (led !== ((n >= 4) ? 10'h001 : 10'h000)) begin
                    n_bad++;
                    $display("FAIL auto_led n=%0d: got %h want %h", n, led,
                             (n >= 4) ? 10'h001 : 10'h000);
                end
            end
        end
    endtask

    task automatic test_manual_wrap();
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        btn_prev = 1'b1;
        tick();
        n_cmp++;
        if ({sel, pat_rst, adv, led} !== {2'd3, 4'b1000, 1'b1, 10'h000}) begin
            n_bad++;
            $display("FAIL wrap_prev: got sel=%0d rst=%b adv=%b led=%h, want 3/1000/1/000",
                     sel, pat_rst, adv, led);
        end
        btn_prev = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (led !== 10'h000) begin
            n_bad++;
            $display("FAIL wrap_blank: got led=%h want 000", led);
        end
        tick();
        n_cmp++;
        if ({led, pat_en} !== {10'h008, 4'b1000}) begin
            n_bad++;
            $display("FAIL wrap_run: got led=%h en=%b want 008/1000", led, pat_en);
        end
        btn_next = 1'b1;
        tick();
        n_cmp++;
        if ({sel, adv} !== {2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_next: got sel=%0d adv=%b want 0/1", sel, adv);
        end
        btn_next = 1'b0;
    endtask

    task automatic test_simultaneous();
        int s0;
        bit found;
        auto_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_age > B && m_run == D - 1) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL simul_wait: dwell 7 not reached, got age=%0d want >%0d", m_age, B);
        end
        s0 = m_sel;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick();
        n_cmp++;
        if ({sel, adv} !== {2'(s0 + 1), 1'b1}) begin
            n_bad++;
            $display("FAIL simul_step: got sel=%0d adv=%b want %0d/1", sel, adv, (s0 + 1) % 4);
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick();
        n_cmp++;
        if ({sel, adv} !== {2'(s0 + 1), 1'b0}) begin
            n_bad++;
            $display("FAIL simul_single: got sel=%0d adv=%b want %0d/0", sel, adv, (s0 + 1) % 4);
        end
    endtask

    task automatic test_edges_in_blank();
        int s1;
        s1 = m_sel;
        btn_next = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({sel, adv, led, pat_en} !== {2'(s1), 1'b0, 10'h000, 4'b0000}) begin
                n_bad++;
                $display("FAIL blank_ignore i=%0d: got sel=%0d adv=%b led=%h en=%b want %0d/0/000/0000",
                         i, sel, adv, led, pat_en, s1);
            end
        end
        tick();
        n_cmp++;
        if ({sel, adv, pat_en} !== {2'(s1), 1'b0, 4'(4'b0001 << s1)}) begin
            n_bad++;
            $display("FAIL blank_len: got sel=%0d adv=%b en=%b want %0d/0/%b",
                     sel, adv, pat_en, s1, 4'(4'b0001 << s1));
        end
        btn_next = 1'b0;
    endtask

    task automatic test_pause();
        int s;
        logic [9:0] l0;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_age > B && m_run == 5) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL pause_wait: dwell 5 not reached, got run=%0d want 5", m_run);
        end
        s  = m_sel;
        l0 = pats[s];
        pause = 1'b1;
        #1;
        n_cmp++;
        if ({pat_en, running} !== {4'b0000, 1'b0}) begin
            n_bad++;
            $display("FAIL pause_comb: got en=%b running=%b want 0000/0", pat_en, running);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({led, sel, adv, pat_en} !== {l0, 2'(s), 1'b0, 4'b0000}) begin
                n_bad++;
                $display("FAIL pause_hold i=%0d: got led=%h sel=%0d adv=%b en=%b want %h/%0d/0/0000",
                         i, led, sel, adv, pat_en, l0, s);
            end
        end
        pause = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (adv !== (i == 3)) begin
                n_bad++;
                $display("FAIL pause_resume i=%0d: got adv=%b want %b", i, adv, i == 3);
            end
        end
        n_cmp++;
        if (sel !== 2'(s + 1)) begin
            n_bad++;
            $display("FAIL pause_resume_sel: got %0d want %0d", sel, (s + 1) % 4);
        end
        for (int i = 0; i < 4; i++) tick();
        pause = 1'b1;
        btn_next = 1'b1;
        tick();
        n_cmp++;
        if ({sel, adv} !== {2'(s + 2), 1'b1}) begin
            n_bad++;
            $display("FAIL pause_btn: got sel=%0d adv=%b want %0d/1", sel, adv, (s + 2) % 4);
        end
        btn_next = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if ({running, pat_en, led} !== {1'b0, 4'b0000, pats[(s + 2) % 4]}) begin
            n_bad++;
            $display("FAIL pause_enter: got running=%b en=%b led=%h want 0/0000/%h",
                     running, pat_en, led, pats[(s + 2) % 4]);
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_mid_blank();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_sel == 2 && m_age >= 1 && m_age <= B) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rstblank_wait: sel 2 blank not reached, got sel=%0d want 2", m_sel);
        end
        btn_next = 1'b1;
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({sel, pat_rst, pat_en, led, adv} !== {2'd0, 4'b0001, 4'b0000, 10'h000, 1'b0}) begin
            n_bad++;
            $display("FAIL rstblank_state: got sel=%0d rst=%b en=%b led=%h adv=%b want 0/0001/0000/000/0",
                     sel, pat_rst, pat_en, led, adv);
        end
        tick();
        rst = 1'b0;
        auto_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({sel, adv} !== {2'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL rstblank_held i=%0d: got sel=%0d adv=%b want 0/0", i, sel, adv);
            end
        end
        btn_next = 1'b0;
        tick();
        btn_next = 1'b1;
        tick();
        n_cmp++;
        if ({sel, adv} !== {2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL rstblank_repress: got sel=%0d adv=%b want 1/1", sel, adv);
        end
        btn_next = 1'b0;
    endtask

    task automatic test_random();
        auto_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 15) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            dir_sw = 1'($urandom);
            tick();
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL random_model i=%0d: got %h want %h", i, dut_vec, model_out());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_auto_cycle();
        test_manual_wrap();
        test_simultaneous();
        test_edges_in_blank();
        test_pause();
        test_reset_mid_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Sequencer for the DE10 LED pattern demo: it owns four free-running pattern generators (10-bit LED outputs with `en`/`dir`/`rst` controls) and decides which one drives `led`. It handles manual next/prev stepping from debounced buttons, timed auto-advance, pause, and a blanking gap between patterns. Only the selected generator is enabled, and each newly selected generator gets a one-cycle reset pulse so it always starts from its seed.

## Interface
- `DWELL_CYCLES`, default 50_000_000: RUN cycles before auto-advance; legal values ≥ 2.
- `BLANK_CYCLES`, default 5_000_000: LED-off cycles between patterns; 0 means no blank.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_next` in 1: debounced, synchronous level; the rising edge steps forward.
- `btn_prev` in 1: debounced, synchronous level; the rising edge steps backward.
- `auto_en` in 1: enables dwell-timed auto-advance.
- `pause` in 1: freezes the running pattern.
- `dir_sw` in 1: direction/invert request forwarded to the generators.
- `pat0`..`pat3` in 10 each: generator outputs.
- `pat_en` out 4: per-generator enable; one-hot or zero.
- `pat_rst` out 4: per-generator synchronous reset; one-hot or zero.
- `pat_dir` out 1: registered copy of `dir_sw`.
- `led` out 10: LED drive.
- `sel` out 2: index of the active pattern.
- `running` out 1: high when in RUN with `pause` low.
- `adv` out 1: one-cycle pulse, high on the cycle `sel` changes.

## Operation
- **States:**
  - SWITCH: exactly 1 cycle.
  - BLANK: exactly `BLANK_CYCLES` cycles.
  - RUN.
- **Transitions:**
  - SWITCH → BLANK, or SWITCH → RUN when `BLANK_CYCLES`=0.
  - BLANK → RUN once the blank counter reaches `BLANK_CYCLES`-1.
  - RUN → SWITCH on an advance event.
- **Advance events:** legal only in RUN. Button edges arriving in SWITCH or BLANK are discarded, not queued.
  - `next_edge` = `btn_next` & ~`btn_next_q`: `sel` ← `sel`+1 mod 4 (3 wraps to 0).
  - `prev_edge` = `btn_prev` & ~`btn_prev_q`: `sel` ← `sel`-1 mod 4 (0 wraps to 3).
  - Auto: `auto_en`=1, `pause`=0, and `dwell` = `DWELL_CYCLES`-1: treated as next.
  - Edge registers update every cycle in every state.
- **Priority when several fire in one cycle:** `next_edge` > `prev_edge` > auto. Exactly one step is taken per cycle.
- **Outputs are combinational from state/`sel`/`pause`:**
  - SWITCH: `pat_rst` = onehot(`sel`), `pat_en`=0, `led`=0.
  - BLANK: `pat_rst`=0, `pat_en`=0, `led`=0.
  - RUN: `pat_rst`=0, `pat_en` = `pause` ? 0 : onehot(`sel`), `led` = `pat[sel]`.
    - While paused, the generator holds, so `led` holds.
- **Dwell counter:**
  - Width is clog2(`DWELL_CYCLES`).
  - Cleared on entry to RUN.
  - Increments in RUN when `auto_en`=1 and `pause`=0; holds otherwise.
  - Never exceeds `DWELL_CYCLES`-1.
- **Blank counter:** cleared on entry to BLANK. `pause` has no effect on BLANK or SWITCH.
- **Manual buttons while paused:** still advance. The new pattern enters RUN paused if `pause` is still high.
- **Reset:**
  - State and registers: state=SWITCH, `sel`=0, `dwell`=0, blank counter=0, `btn_*_q`=0, `pat_dir`=0, `adv`=0.
  - Outputs during and immediately after reset: `pat_rst`=4'b0001, `pat_en`=0, `led`=0, `running`=0.
  - A button level that is already high when reset releases does not count as an edge until it drops and rises again. To achieve this, the edge registers load the current button level, not 0, on the first non-reset cycle after reset.
- **Reset mid-operation:** abandons any state immediately; the reset values above apply on the next edge.

## Timing
- **Button step latency:** rising edge sampled at clock k while in RUN gives:
  - At k+1: `sel` updated, state=SWITCH, `adv`=1, `pat_rst` pulse, `led`=0.
  - BLANK from k+2 to k+1+`BLANK_CYCLES`.
  - RUN with `pat_en` asserted at k+2+`BLANK_CYCLES`.
- **Auto step:** with `auto_en` held high and no pause, RUN lasts exactly `DWELL_CYCLES` cycles per pattern.
  - Full period per pattern is `DWELL_CYCLES`+1+`BLANK_CYCLES`.
- **Pause:** `pause` rising at clock k means `pat_en`=0 and `running`=0 from the same cycle (combinational). Dwell holds its value and resumes from it.
- **`pat_dir`:** 1-cycle registered delay from `dir_sw`, in all states.
- **`adv`:** high for exactly one cycle per step, coincident with SWITCH. It is not asserted for the reset-entry SWITCH.

## Test plan
All scenarios use `DWELL_CYCLES`=8 and `BLANK_CYCLES`=3. The bench drives `pat0..3` = 10'h001, 10'h002, 10'h004, 10'h008.
1. **Reset and auto-cycle.**
   - Stimulus: release reset with `auto_en`=1.
   - Response: `pat_rst`=0001 for 1 cycle, `led`=0 for 3 cycles, then `led`=10'h001 for 8 cycles.
   - Then `adv` pulses and `sel`=1; the sequence runs 0→1→2→3→0 with period 12.
2. **Manual wrap.**
   - Stimulus: `auto_en`=0; `btn_prev` edge at `sel`=0.
   - Response: `sel`=3, `pat_rst`=1000, then `led`=10'h008 after 4 cycles.
   - A following `btn_next` edge gives `sel`=0.
3. **Simultaneous events.**
   - Stimulus: `btn_next` and `btn_prev` rise together on the same cycle that dwell hits 7.
   - Response: a single step to `sel`+1 and exactly one `adv` pulse.
4. **Edges during SWITCH/BLANK.**
   - Stimulus: `btn_next` edge 2 cycles after an advance.
   - Response: ignored; `sel` is unchanged and the blank length stays 3.
5. **Pause.**
   - Stimulus: `pause`=1 at dwell=5 for 20 cycles.
   - Response: `pat_en`=0, `led` stable, no advance.
   - After release, advance occurs exactly 3 cycles later.
   - A `btn_next` edge while paused still steps.
6. **Reset mid-BLANK.**
   - Stimulus: assert `rst` while in BLANK with `sel`=2 and `btn_next` held high.
   - Response: `sel`=0, `pat_rst`=0001.
   - The held button produces no step until it is released and pressed again.
